// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_loader_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte shifted in ends up in the MSBs.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full
);
    logic [1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (clear) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (shift) begin
            cnt  <= cnt + 2'd1;
            word <= {word[WORD_W-BYTE_W-1:0], byte_in};
        end
    end

    // Counter wraps to zero on the completing byte, so no explicit clear is needed per word.
    assign full = shift && (cnt == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: packs a byte stream into words, writes them to instruction
// memory, and holds the CPU in reset until the requested word count is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    imem_loader_if.slave      bus,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] checksum
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] word_idx;
    logic [WORD_W-1:0] word;
    logic              full, start_ok, load_ok, last_word, handshake;

    assign start_ok  = start && (state == IDLE || state == DONE || state == ERROR);
    assign load_ok   = start_ok && (word_count <= DEPTH);
    assign last_word = ({1'b0, word_idx} == count - (ADDR_W+1)'(1));
    assign handshake = bus.byte_valid && bus.byte_ready;

    imem_loader_byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (load_ok),
        .shift   (handshake),
        .byte_in (bus.byte_in),
        .word    (word),
        .full    (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    if (word_count == '0)        state_nxt = DONE;
                    else if (word_count > DEPTH) state_nxt = ERROR;
                    else                         state_nxt = COLLECT;
                end
            end
            COLLECT: if (full) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            word_idx <= '0;
            checksum <= '0;
        end else if (load_ok) begin
            count    <= word_count;
            word_idx <= '0;
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum ^ word;
            if (!last_word) word_idx <= word_idx + ADDR_W'(1);
        end
    end

    // All outputs decode from state/registers only; nothing depends on byte_valid.
    assign bus.byte_ready = (state == COLLECT);
    assign bus.imem_we    = (state == WRITE);
    assign bus.imem_addr  = BASE_ADDR + {{(30-ADDR_W){1'b0}}, word_idx, 2'b00};
    assign bus.imem_wdata = word;
    assign cpu_reset      = (state != DONE);
    assign busy           = (state == COLLECT) || (state == WRITE);
    assign done           = (state == DONE);
    assign error          = (state == ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a word-list reference model.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              cpu_reset, busy, done, error;
    logic [31:0]       checksum;

    imem_loader_if bus();

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int c);
        @(negedge clk);
        start      = 1'b1;
        word_count = (ADDR_W+1)'(c);
        @(negedge clk);
        start      = 1'b0;
    endtask

    // density: percent of cycles with byte_valid, or -1 for the 1,0,0 pattern.
    // spur: cycle at which a stray start (count 0) is pulsed mid-load, 0 for none.
    task automatic run_load(input int cnt, input bq_t bytes, input int density,
                            input int spur, input string tag);
        int base, idx, cyc;
        logic [31:0] exp_w, exp_ck;
        base = wr_addr.size();
        idx = 0;
        cyc = 0;
        exp_ck = 32'h0;
        pulse_start(cnt);
        while (idx < bytes.size() && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start      = (cyc == spur);
            word_count = '0;
            if (density < 0) bus.byte_valid = (cyc % 3 == 1);
            else             bus.byte_valid = ($urandom_range(0, 99) < density);
            bus.byte_in = bytes[idx];
            if (bus.byte_valid && bus.byte_ready) idx++;
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        start = 1'b0;
        check({tag, " bytes consumed"}, 32'(idx), 32'(bytes.size()));
        cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check({tag, " write count"}, 32'(wr_addr.size() - base), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            exp_w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
            exp_ck ^= exp_w;
            if (base + i < wr_addr.size()) begin
                check($sformatf("%s addr[%0d]", tag, i), wr_addr[base+i], 32'(4 * i));
                check($sformatf("%s data[%0d]", tag, i), wr_data[base+i], exp_w);
            end
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " checksum"}, checksum, exp_ck);
    endtask

    initial begin
        bq_t q;
        int n, base, idx;

        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;

        repeat (3) @(negedge clk);
        check("rst cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst imem_we", 32'(bus.imem_we), 32'd0);
        check("rst checksum", checksum, 32'h0);
        check("rst imem_addr", bus.imem_addr, 32'h0);
        check("rst imem_wdata", bus.imem_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("idle cpu_reset", 32'(cpu_reset), 32'd1);
        check("idle busy", 32'(busy), 32'd0);

        q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        run_load(2, q, 100, 0, "two");
        check("two checksum const", checksum, 32'hAC030001);
        run_load(2, q, -1, 0, "toggle");

        base = wr_addr.size();
        pulse_start(0);
        check("zero done", 32'(done), 32'd1);
        check("zero checksum", checksum, 32'h0);
        repeat (3) @(negedge clk);
        check("zero writes", 32'(wr_addr.size() - base), 32'd0);

        pulse_start(DEPTH + 1);
        check("err error", 32'(error), 32'd1);
        check("err cpu_reset", 32'(cpu_reset), 32'd1);
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err byte_ready", 32'(bus.byte_ready), 32'd0);
        end
        bus.byte_valid = 1'b0;

        base = wr_addr.size();
        pulse_start(1);
        idx = 0;
        q = '{8'hAA, 8'hBB};
        while (idx < 2) begin
            bus.byte_valid = 1'b1;
            bus.byte_in = q[idx];
            if (bus.byte_ready) idx++;
            if (idx < 2) @(negedge clk);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst byte_ready", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst writes", 32'(wr_addr.size() - base), 32'd0);

        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(1, q, 60, 3, "deadbeef");

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 6);
            q = {};
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            run_load(n, q, $urandom_range(20, 100), ($urandom_range(0, 1) == 1) ? 4 : 0,
                     $sformatf("rnd%0d", t));
        end

        q = {};
        for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
        run_load(DEPTH, q, 100, 0, "full");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
